// File: rtl/dmg_pkg.sv
// Shared types and address map for the DMG CPU bus controller.
package dmg_pkg;

   typedef enum logic [3:0] {
      RgnNone, RgnRom, RgnBoot, RgnVram, RgnWram, RgnOam, RgnZero,
      RgnIf, RgnPpu, RgnDma, RgnBootReg, RgnHram, RgnIe
   } region_t;

   typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_XFER} dma_state_t;

   localparam logic [15:0] ADDR_ROM_MASK  = 16'h8000;
   localparam logic [15:0] ADDR_ROM       = 16'h0000;
   localparam logic [15:0] ADDR_VRAM_MASK = 16'hE000;
   localparam logic [15:0] ADDR_VRAM      = 16'h8000;
   localparam logic [15:0] ADDR_WRAM_MASK = 16'hE000;
   localparam logic [15:0] ADDR_WRAM      = 16'hC000;
   localparam logic [15:0] ADDR_ECHO_MASK = 16'hE000;
   localparam logic [15:0] ADDR_ECHO      = 16'hE000;
   localparam logic [15:0] ADDR_OAM_MASK  = 16'hFF00;
   localparam logic [15:0] ADDR_OAM       = 16'hFE00;
   localparam logic [15:0] ADDR_IO_MASK   = 16'hFFF0;
   localparam logic [15:0] ADDR_IO_PPU    = 16'hFF40;
   localparam logic [15:0] ADDR_HRAM_MASK = 16'hFF80;
   localparam logic [15:0] ADDR_HRAM      = 16'hFF80;

   localparam logic [15:0] REG_IF   = 16'hFF0F;
   localparam logic [15:0] REG_DMA  = 16'hFF46;
   localparam logic [15:0] REG_BOOT = 16'hFF50;
   localparam logic [15:0] REG_IE   = 16'hFFFF;

   function automatic logic addr_hit(input logic [15:0] addr, input logic [15:0] mask,
                                     input logic [15:0] match);
      return (addr & mask) == match;
   endfunction

   function automatic region_t decode_region(input logic [15:0] addr, input logic boot_on,
                                             input int unsigned boot_size,
                                             input int unsigned hram_depth);
      region_t rgn;
      rgn = RgnNone;
      if (addr_hit(addr, ADDR_ROM_MASK, ADDR_ROM)) begin
         rgn = (boot_on && (32'(addr) < boot_size)) ? RgnBoot : RgnRom;
      end else if (addr_hit(addr, ADDR_VRAM_MASK, ADDR_VRAM)) begin
         rgn = RgnVram;
      end else if (addr_hit(addr, ADDR_WRAM_MASK, ADDR_WRAM) ||
                   (addr_hit(addr, ADDR_ECHO_MASK, ADDR_ECHO) && addr < ADDR_OAM)) begin
         rgn = RgnWram;
      end else if (addr_hit(addr, ADDR_OAM_MASK, ADDR_OAM)) begin
         rgn = (addr[7:0] < 8'hA0) ? RgnOam : RgnZero;
      end else if (addr == REG_IF) begin
         rgn = RgnIf;
      end else if (addr == REG_DMA) begin
         rgn = RgnDma;
      end else if (addr_hit(addr, ADDR_IO_MASK, ADDR_IO_PPU) && addr[3:0] <= 4'hB) begin
         rgn = RgnPpu;
      end else if (addr == REG_BOOT) begin
         rgn = RgnBootReg;
      end else if (addr == REG_IE) begin
         rgn = RgnIe;
      end else if (addr_hit(addr, ADDR_HRAM_MASK, ADDR_HRAM) &&
                   (32'(addr) < 32'(ADDR_HRAM) + hram_depth)) begin
         rgn = RgnHram;
      end
      return rgn;
   endfunction

   // Echo-area pages E0h..FFh alias back onto WRAM.
   function automatic logic [7:0] fold_src(input logic [7:0] src);
      return (src >= 8'hE0) ? (src - 8'h20) : src;
   endfunction

endpackage

// File: rtl/dmg_oam_dma.sv
// OAM DMA engine: one START M-cycle, then DMA_LEN byte transfers from {src, index}.
module dmg_oam_dma
   import dmg_pkg::*;
#(
   parameter int unsigned DMA_LEN = 160
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        start,
   input  logic [7:0]  src,
   output logic        active,
   output logic        xfer,
   output logic [7:0]  src_reg,
   output logic [7:0]  index,
   output logic [15:0] bus_addr
);

   localparam logic [7:0] LastIdx = 8'(DMA_LEN - 1);

   dma_state_t state_q, state_d;
   logic [7:0] src_q;
   logic [7:0] idx_q, idx_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DMA_IDLE;
         src_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (start) begin
            src_q <= src;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (start) begin
         state_d = DMA_START;
         idx_d   = '0;
      end else if (ce) begin
         case (state_q)
            DMA_IDLE:  state_d = DMA_IDLE;
            DMA_START: begin
               state_d = DMA_XFER;
               idx_d   = '0;
            end
            DMA_XFER: begin
               if (idx_q == LastIdx) begin
                  state_d = DMA_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
            default:   state_d = DMA_IDLE;
         endcase
      end
   end

   always_comb begin
      active   = (state_q != DMA_IDLE);
      xfer     = (state_q == DMA_XFER);
      src_reg  = src_q;
      index    = idx_q;
      bus_addr = {fold_src(src_q), idx_q};
   end

endmodule

// File: rtl/dmg_bus_ctrl.sv
// DMG CPU bus controller: region decode, read mux, boot overlay, HRAM, IF/IE and OAM DMA.
module dmg_bus_ctrl
   import dmg_pkg::*;
#(
   parameter int unsigned BOOT_SIZE  = 256,
   parameter int unsigned HRAM_DEPTH = 127,
   parameter int unsigned DMA_LEN    = 160,
   parameter int unsigned N_IRQ      = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic [15:0]      cpu_addr,
   input  logic [7:0]       cpu_d_out,
   input  logic             cpu_write,
   output logic [7:0]       cpu_d_in,
   output logic [15:0]      mem_addr,
   output logic [7:0]       mem_d_wr,
   input  logic [7:0]       rom_data,
   input  logic [7:0]       boot_data,
   input  logic [7:0]       vram_d_rd,
   input  logic [7:0]       wram_d_rd,
   input  logic [7:0]       oam_d_rd,
   input  logic [7:0]       ppu_d_rd,
   output logic             vram_write,
   output logic             wram_write,
   output logic             oam_write,
   output logic             ppu_reg_write,
   output logic [7:0]       oam_addr,
   output logic [7:0]       oam_d_wr,
   input  logic [N_IRQ-1:0] irq_req,
   output logic [N_IRQ-1:0] irq_pend,
   output logic             hide_boot,
   output logic             dma_active
);

   localparam int unsigned HramAw = (HRAM_DEPTH > 1) ? $clog2(HRAM_DEPTH) : 1;

   region_t cpu_rgn, bus_rgn;
   logic cpu_wr, cpu_free, dma_start, dma_xfer;
   logic [7:0] dma_reg, dma_idx;
   logic [15:0] dma_addr;
   logic hide_boot_q;
   logic [N_IRQ-1:0] if_q, if_d, ie_q;
   logic [7:0] hram_q [HRAM_DEPTH];
   logic [HramAw-1:0] hram_idx;
   logic [7:0] hram_rd, bus_data, if_rd, ie_rd;

   dmg_oam_dma #(
      .DMA_LEN (DMA_LEN)
   ) u_dma (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .start    (dma_start),
      .src      (cpu_d_out),
      .active   (dma_active),
      .xfer     (dma_xfer),
      .src_reg  (dma_reg),
      .index    (dma_idx),
      .bus_addr (dma_addr)
   );

   assign cpu_rgn   = decode_region(cpu_addr, !hide_boot_q, BOOT_SIZE, HRAM_DEPTH);
   assign cpu_wr    = cpu_write & ce;
   // While DMA owns the bus the CPU only sees HRAM and the DMA register.
   assign cpu_free  = !dma_active || (cpu_rgn inside {RgnHram, RgnDma});
   assign dma_start = cpu_wr && (cpu_rgn == RgnDma);
   assign bus_rgn   = dma_active ? decode_region(dma_addr, !hide_boot_q, BOOT_SIZE, HRAM_DEPTH)
                                 : cpu_rgn;
   assign hram_idx  = HramAw'(cpu_addr - ADDR_HRAM);
   assign hram_rd   = hram_q[hram_idx];

   always_comb begin
      mem_addr = cpu_addr;
      if (dma_active) begin
         mem_addr = dma_addr;
      end else if (cpu_rgn == RgnWram) begin
         mem_addr[13] = 1'b0;
      end
   end

   always_comb begin
      if_rd              = 8'hFF;
      if_rd[N_IRQ-1:0]   = if_q;
      ie_rd              = 8'hFF;
      ie_rd[N_IRQ-1:0]   = ie_q;
   end

   always_comb begin
      case (bus_rgn)
         RgnRom:  bus_data = rom_data;
         RgnBoot: bus_data = boot_data;
         RgnVram: bus_data = vram_d_rd;
         RgnWram: bus_data = wram_d_rd;
         RgnOam:  bus_data = oam_d_rd;
         RgnZero: bus_data = 8'h00;
         RgnIf:   bus_data = if_rd;
         RgnPpu:  bus_data = ppu_d_rd;
         RgnDma:  bus_data = dma_reg;
         RgnHram: bus_data = hram_rd;
         RgnIe:   bus_data = ie_rd;
         default: bus_data = 8'hFF;
      endcase
   end

   always_comb begin
      cpu_d_in = bus_data;
      if (dma_active) begin
         if (cpu_rgn == RgnHram) begin
            cpu_d_in = hram_rd;
         end else if (cpu_rgn == RgnDma) begin
            cpu_d_in = dma_reg;
         end else begin
            cpu_d_in = 8'hFF;
         end
      end
   end

   always_comb begin
      mem_d_wr      = cpu_d_out;
      vram_write    = cpu_wr && cpu_free && (cpu_rgn == RgnVram);
      wram_write    = cpu_wr && cpu_free && (cpu_rgn == RgnWram);
      ppu_reg_write = cpu_wr && cpu_free && (cpu_rgn == RgnPpu);
      oam_write     = dma_xfer ? (ce && !rst) : (cpu_wr && cpu_free && (cpu_rgn == RgnOam));
      oam_addr      = dma_xfer ? dma_idx : cpu_addr[7:0];
      oam_d_wr      = dma_xfer ? bus_data : cpu_d_out;
      irq_pend      = if_q & ie_q;
      hide_boot     = hide_boot_q;
   end

   // Peripheral request pulses take priority over a same-cycle CPU write to IF.
   always_comb begin
      if_d = if_q;
      if (cpu_wr && cpu_free && (cpu_rgn == RgnIf)) begin
         if_d = cpu_d_out[N_IRQ-1:0];
      end
      if_d = if_d | irq_req;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hide_boot_q <= 1'b0;
         if_q        <= '0;
         ie_q        <= '0;
      end else begin
         if_q <= if_d;
         if (cpu_wr && cpu_free && (cpu_rgn == RgnIe)) begin
            ie_q <= cpu_d_out[N_IRQ-1:0];
         end
         if (cpu_wr && cpu_free && (cpu_rgn == RgnBootReg) && (cpu_d_out != 8'h00)) begin
            hide_boot_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (cpu_wr && (cpu_rgn == RgnHram)) begin
         hram_q[hram_idx] <= cpu_d_out;
      end
   end

endmodule

// File: tb/tb_dmg_bus_ctrl.sv
// Scoreboard bench for dmg_bus_ctrl: stimulus queues expected events, a negedge monitor checks.
module tb_dmg_bus_ctrl;

   localparam int N_IRQ = 5;
   localparam int PrRd = 0, PrPend = 1, PrAct = 2, PrHide = 3;
   localparam int WrVram = 1, WrWram = 2, WrPpu = 3;
   localparam logic [7:0] BootByte = 8'h5B, VramByte = 8'h80, OamByte = 8'h0A, PpuByte = 8'h91;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  idx;
      logic [7:0]  data;
      logic [31:0] t;
   } ev_t;

   logic clk = 1'b0;
   logic rst, ce, cpu_write;
   logic [15:0] cpu_addr, mem_addr;
   logic [7:0] cpu_d_out, cpu_d_in, mem_d_wr;
   logic [7:0] rom_data, boot_data, vram_d_rd, wram_d_rd, oam_d_rd, ppu_d_rd;
   logic vram_write, wram_write, oam_write, ppu_reg_write, hide_boot, dma_active;
   logic [7:0] oam_addr, oam_d_wr;
   logic [N_IRQ-1:0] irq_req, irq_pend;

   logic probe = 1'b0;
   int probe_kind = 0;
   int cyc = 0;
   int compared = 0, mismatched = 0;
   ev_t q_oam[$], q_wr[$], q_pr[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] rom_f(input logic [15:0] a);
      return a[7:0] ^ 8'hA5;
   endfunction
   function automatic logic [7:0] wram_f(input logic [15:0] a);
      return a[7:0] + a[15:8];
   endfunction

   assign rom_data  = rom_f(mem_addr);
   assign wram_d_rd = wram_f(mem_addr);
   assign boot_data = BootByte;
   assign vram_d_rd = VramByte;
   assign oam_d_rd  = OamByte;
   assign ppu_d_rd  = PpuByte;

   dmg_bus_ctrl #(
      .BOOT_SIZE  (256),
      .HRAM_DEPTH (127),
      .DMA_LEN    (160),
      .N_IRQ      (N_IRQ)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ce            (ce),
      .cpu_addr      (cpu_addr),
      .cpu_d_out     (cpu_d_out),
      .cpu_write     (cpu_write),
      .cpu_d_in      (cpu_d_in),
      .mem_addr      (mem_addr),
      .mem_d_wr      (mem_d_wr),
      .rom_data      (rom_data),
      .boot_data     (boot_data),
      .vram_d_rd     (vram_d_rd),
      .wram_d_rd     (wram_d_rd),
      .oam_d_rd      (oam_d_rd),
      .ppu_d_rd      (ppu_d_rd),
      .vram_write    (vram_write),
      .wram_write    (wram_write),
      .oam_write     (oam_write),
      .ppu_reg_write (ppu_reg_write),
      .oam_addr      (oam_addr),
      .oam_d_wr      (oam_d_wr),
      .irq_req       (irq_req),
      .irq_pend      (irq_pend),
      .hide_boot     (hide_boot),
      .dma_active    (dma_active)
   );

   task automatic cmp(input string nm, input bit have, input ev_t e, input ev_t a,
                      input bit use_t);
      compared++;
      if (!have) begin
         mismatched++;
         $display("FAIL %s unexpected event: addr=%h idx=%h data=%h cyc=%0d",
                  nm, a.addr, a.idx, a.data, a.t);
      end else if (e.addr !== a.addr || e.idx !== a.idx || e.data !== a.data ||
                   (use_t && e.t != a.t)) begin
         mismatched++;
         $display("FAIL %s: got addr=%h idx=%h data=%h cyc=%0d, expected addr=%h idx=%h data=%h cyc=%0d",
                  nm, a.addr, a.idx, a.data, a.t, e.addr, e.idx, e.data, e.t);
      end
   endtask

   // Monitor: every DUT output event pops the matching queue.
   always @(negedge clk) begin : monitor
      ev_t a, e;
      bit have;
      if (probe) begin
         a.addr = cpu_addr;
         a.idx  = 8'(probe_kind);
         a.t    = 32'(cyc);
         case (probe_kind)
            PrRd:    a.data = cpu_d_in;
            PrPend:  a.data = 8'(irq_pend);
            PrAct:   a.data = {7'b0, dma_active};
            default: a.data = {7'b0, hide_boot};
         endcase
         have = q_pr.size() > 0;
         e = have ? q_pr.pop_front() : '0;
         cmp("probe", have, e, a, 1'b0);
      end
      if (vram_write || wram_write || ppu_reg_write) begin
         a.addr = mem_addr;
         a.idx  = vram_write ? 8'(WrVram) : (wram_write ? 8'(WrWram) : 8'(WrPpu));
         a.data = mem_d_wr;
         a.t    = 32'(cyc);
         have = q_wr.size() > 0;
         e = have ? q_wr.pop_front() : '0;
         cmp("region_write", have, e, a, 1'b0);
      end
      if (oam_write) begin
         a.addr = mem_addr;
         a.idx  = oam_addr;
         a.data = oam_d_wr;
         a.t    = 32'(cyc);
         have = q_oam.size() > 0;
         e = have ? q_oam.pop_front() : '0;
         cmp("oam_write", have, e, a, 1'b1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
      cpu_addr  = a;
      cpu_d_out = d;
      cpu_write = 1'b1;
      tick();
      cpu_write = 1'b0;
   endtask

   task automatic exp_wr(input int kind, input logic [15:0] a, input logic [7:0] d);
      q_wr.push_back('{addr: a, idx: 8'(kind), data: d, t: 32'(0)});
   endtask

   task automatic chk(input int kind, input logic [7:0] d);
      q_pr.push_back('{addr: cpu_addr, idx: 8'(kind), data: d, t: 32'(0)});
      probe      = 1'b1;
      probe_kind = kind;
      tick();
      probe = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, input logic [7:0] d);
      cpu_addr = a;
      chk(PrRd, d);
   endtask

   task automatic push_dma(input logic [15:0] base, input int t0, input int n);
      for (int i = 0; i < n; i++) begin
         q_oam.push_back('{addr: base + 16'(i), idx: 8'(i), data: wram_f(base + 16'(i)),
                           t: 32'(t0 + i)});
      end
   endtask

   task automatic drain(input string nm, input int n);
      for (int i = 0; i < n; i++) begin
         compared++;
         mismatched++;
         $display("FAIL %s missing: %0d expected event(s) never seen", nm, n - i);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int w, w2;
      rst = 1'b1; ce = 1'b1; cpu_write = 1'b0; irq_req = '0;
      cpu_addr = 16'h0000; cpu_d_out = 8'h00;
      repeat (3) tick();
      rst = 1'b0;

      // Reset state
      chk(PrAct, 8'h00);
      chk(PrHide, 8'h00);
      chk(PrPend, 8'h00);
      rd(16'hFF0F, 8'hE0);
      rd(16'hFFFF, 8'hE0);
      rd(16'hFF46, 8'h00);

      // Boot overlay
      rd(16'h0005, BootByte);
      rd(16'h0100, 8'hA5);
      cpu_wr(16'hFF50, 8'h00);
      rd(16'h0005, BootByte);
      cpu_wr(16'hFF50, 8'h01);
      rd(16'h0005, 8'hA0);
      chk(PrHide, 8'h01);

      // Misc decode and write strobes
      rd(16'h8000, VramByte);
      rd(16'hFE10, OamByte);
      rd(16'hFEA0, 8'h00);
      rd(16'hA000, 8'hFF);
      rd(16'hFF44, PpuByte);
      rd(16'hFF03, 8'hFF);
      exp_wr(WrVram, 16'h8010, 8'h12);
      cpu_wr(16'h8010, 8'h12);
      exp_wr(WrPpu, 16'hFF40, 8'h91);
      cpu_wr(16'hFF40, 8'h91);
      q_oam.push_back('{addr: 16'hFE10, idx: 8'h10, data: 8'h33, t: 32'(cyc)});
      cpu_wr(16'hFE10, 8'h33);
      ce = 1'b0;
      cpu_wr(16'hC000, 8'h77);
      ce = 1'b1;
      cpu_wr(16'hFF80, 8'h3C);
      cpu_wr(16'hFFFE, 8'hC3);
      rd(16'hFF80, 8'h3C);
      rd(16'hFFFE, 8'hC3);

      // Echo
      exp_wr(WrWram, 16'hC123, 8'h5A);
      cpu_wr(16'hE123, 8'h5A);
      rd(16'hC123, 8'hE4);
      rd(16'hE123, 8'hE4);

      // Interrupts
      cpu_wr(16'hFFFF, 8'h01);
      rd(16'hFFFF, 8'hE1);
      irq_req = 5'b00001;
      tick();
      irq_req = '0;
      chk(PrPend, 8'h01);
      irq_req = 5'b00001;
      cpu_wr(16'hFF0F, 8'h00);
      irq_req = '0;
      rd(16'hFF0F, 8'hE1);
      chk(PrPend, 8'h01);
      cpu_wr(16'hFF0F, 8'h1E);
      rd(16'hFF0F, 8'hFE);
      chk(PrPend, 8'h00);

      // Full DMA from C100 with CPU lockout
      w = cyc;
      push_dma(16'hC100, w + 2, 160);
      cpu_wr(16'hFF46, 8'hC1);
      chk(PrAct, 8'h01);
      rd(16'h8000, 8'hFF);
      cpu_wr(16'hC000, 8'h55);
      cpu_wr(16'hFF90, 8'h6D);
      rd(16'hFF90, 8'h6D);
      rd(16'hFF46, 8'hC1);
      rd(16'hFFFF, 8'hFF);
      cpu_wr(16'hFFFF, 8'h00);
      chk(PrAct, 8'h01);
      while (cyc < w + 162) tick();
      chk(PrAct, 8'h00);
      rd(16'hFFFF, 8'hE1);

      // Restart at index 50
      w = cyc;
      push_dma(16'hC800, w + 2, 51);
      cpu_wr(16'hFF46, 8'hC8);
      while (cyc < w + 52) tick();
      w2 = cyc;
      push_dma(16'hD000, w2 + 2, 160);
      cpu_wr(16'hFF46, 8'hD0);
      chk(PrAct, 8'h01);
      rd(16'hFF46, 8'hD0);
      while (cyc < w2 + 162) tick();
      chk(PrAct, 8'h00);

      // Source FE folds to DE00; reset aborts after 10 transfers
      w = cyc;
      push_dma(16'hDE00, w + 2, 10);
      cpu_wr(16'hFF46, 8'hFE);
      while (cyc < w + 12) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk(PrAct, 8'h00);
      chk(PrHide, 8'h00);
      rd(16'h0005, BootByte);
      rd(16'hFF46, 8'h00);
      rd(16'hFF0F, 8'hE0);
      rd(16'hFF80, 8'h3C);
      repeat (5) tick();

      drain("oam_write", q_oam.size());
      drain("region_write", q_wr.size());
      drain("probe", q_pr.size());
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
